// File: rtl/mrx_pkg.sv
// Shared types and constants for the Manchester frame receiver.
// CRC constants are used only when FCS_CHECK_EN is defined.
package mrx_pkg;

  typedef enum logic [0:0] {
    StHunt = 1'b0,
    StData = 1'b1
  } mrx_state_e;

  // 0x55 then 0xD5, LSB first, Manchester encoded, first sample in the MSB
  localparam logic [31:0] PREAMBLE_SFD_ENC = 32'h6666_6665;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32.
// Data bits are consumed LSB first; the register is kept in reflected form.
module eth_crc32_byte
  import mrx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] PolyRefl = reflect32(CRC_POLY);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i]) begin
        crc_o = (crc_o >> 1) ^ PolyRefl;
      end else begin
        crc_o = crc_o >> 1;
      end
    end
  end

endmodule

// File: rtl/manchester_frame_rx.sv
// Manchester receive front end: preamble/SFD hunt, half-bit decode, byte stream, UDP port capture.
// Define FCS_CHECK_EN to add CRC-32 FCS checking into done_err.
module manchester_frame_rx
  import mrx_pkg::*;
#(
  parameter int unsigned MAX_BYTES    = 1522,
  parameter int unsigned SRC_PORT_OFS = 34,
  parameter int unsigned DST_PORT_OFS = 36,
  localparam int unsigned LEN_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             encoded,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             done,
  output logic             done_err,
  output logic [LEN_W-1:0] done_len,
  output logic [15:0]      src_port,
  output logic [15:0]      dst_port,
  output logic             ports_valid
);

  mrx_state_e       state_q, state_d;
  logic [31:0]      win_q, win_d;
  logic             phase_q, phase_d;
  logic             half_q, half_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_sr_q, byte_sr_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      src_w_q, src_w_d;
  logic [15:0]      dst_w_q, dst_w_d;
  logic             src_seen_q, src_seen_d;
  logic             dst_seen_q, dst_seen_d;

  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_sof_q, m_sof_d;
  logic             done_q, done_d;
  logic             done_err_q, done_err_d;
  logic [LEN_W-1:0] done_len_q, done_len_d;
  logic [15:0]      src_port_q, src_port_d;
  logic [15:0]      dst_port_q, dst_port_d;
  logic             ports_valid_q, ports_valid_d;

  logic [7:0]       new_byte;
  logic             sfd_hit;
  logic             frame_end;
  logic             emit;
  logic             fcs_bad;

  // Byte as it stands once the current half-bit pair is shifted in
  assign new_byte = {encoded, byte_sr_q[7:1]};

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    phase_d       = phase_q;
    half_d        = half_q;
    bit_cnt_d     = bit_cnt_q;
    byte_sr_d     = byte_sr_q;
    byte_cnt_d    = byte_cnt_q;
    ovf_d         = ovf_q;
    src_w_d       = src_w_q;
    dst_w_d       = dst_w_q;
    src_seen_d    = src_seen_q;
    dst_seen_d    = dst_seen_q;
    m_data_d      = m_data_q;
    m_valid_d     = 1'b0;
    m_sof_d       = 1'b0;
    done_d        = 1'b0;
    done_err_d    = done_err_q;
    done_len_d    = done_len_q;
    src_port_d    = src_port_q;
    dst_port_d    = dst_port_q;
    ports_valid_d = ports_valid_q;
    sfd_hit       = 1'b0;
    frame_end     = 1'b0;
    emit          = 1'b0;

    unique case (state_q)
      StHunt: begin
        win_d = {win_q[30:0], encoded};
        if (win_d == PREAMBLE_SFD_ENC) begin
          sfd_hit    = 1'b1;
          state_d    = StData;
          win_d      = '0;
          phase_d    = 1'b0;
          half_d     = 1'b0;
          bit_cnt_d  = '0;
          byte_sr_d  = '0;
          byte_cnt_d = '0;
          ovf_d      = 1'b0;
          src_seen_d = 1'b0;
          dst_seen_d = 1'b0;
        end
      end
      StData: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          half_d = encoded;
        end else if (half_q != encoded) begin
          byte_sr_d = new_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == LEN_W'(MAX_BYTES)) begin
              ovf_d = 1'b1;
            end else begin
              emit       = 1'b1;
              m_valid_d  = 1'b1;
              m_data_d   = new_byte;
              m_sof_d    = (byte_cnt_q == '0);
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
              if (byte_cnt_q == LEN_W'(SRC_PORT_OFS)) src_w_d[15:8] = new_byte;
              if (byte_cnt_q == LEN_W'(SRC_PORT_OFS + 1)) begin
                src_w_d[7:0] = new_byte;
                src_seen_d   = 1'b1;
              end
              if (byte_cnt_q == LEN_W'(DST_PORT_OFS)) dst_w_d[15:8] = new_byte;
              if (byte_cnt_q == LEN_W'(DST_PORT_OFS + 1)) begin
                dst_w_d[7:0] = new_byte;
                dst_seen_d   = 1'b1;
              end
            end
          end
        end else begin
          // Invalid pair (00/11) is line idle: close the frame
          frame_end     = 1'b1;
          done_d        = 1'b1;
          done_err_d    = ovf_q | (bit_cnt_q != 3'd0) | (byte_cnt_q == '0) | fcs_bad;
          done_len_d    = byte_cnt_q;
          src_port_d    = src_w_q;
          dst_port_d    = dst_w_q;
          ports_valid_d = src_seen_q & dst_seen_q;
          state_d       = StHunt;
          win_d         = '0;
          phase_d       = 1'b0;
          half_d        = 1'b0;
          bit_cnt_d     = '0;
          byte_sr_d     = '0;
          byte_cnt_d    = '0;
          ovf_d         = 1'b0;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      win_q         <= '0;
      phase_q       <= 1'b0;
      half_q        <= 1'b0;
      bit_cnt_q     <= '0;
      byte_sr_q     <= '0;
      byte_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      src_w_q       <= '0;
      dst_w_q       <= '0;
      src_seen_q    <= 1'b0;
      dst_seen_q    <= 1'b0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_sof_q       <= 1'b0;
      done_q        <= 1'b0;
      done_err_q    <= 1'b0;
      done_len_q    <= '0;
      src_port_q    <= '0;
      dst_port_q    <= '0;
      ports_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      phase_q       <= phase_d;
      half_q        <= half_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_sr_q     <= byte_sr_d;
      byte_cnt_q    <= byte_cnt_d;
      ovf_q         <= ovf_d;
      src_w_q       <= src_w_d;
      dst_w_q       <= dst_w_d;
      src_seen_q    <= src_seen_d;
      dst_seen_q    <= dst_seen_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_sof_q       <= m_sof_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
      done_len_q    <= done_len_d;
      src_port_q    <= src_port_d;
      dst_port_q    <= dst_port_d;
      ports_valid_q <= ports_valid_d;
    end
  end

`ifdef FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_step;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (new_byte),
    .crc_o  (crc_step)
  );

  always_comb begin
    crc_d = crc_q;
    if (sfd_hit || frame_end) begin
      crc_d = CRC_INIT;
    end else if (emit) begin
      crc_d = crc_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Register holds the residue reflected; flip it back before comparing
  assign fcs_bad = (reflect32(crc_q) != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_sof       = m_sof_q;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign done_len    = done_len_q;
  assign src_port    = src_port_q;
  assign dst_port    = dst_port_q;
  assign ports_valid = ports_valid_q;

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Directed self-checking bench for manchester_frame_rx (default parameters).
module tb_manchester_frame_rx;

  localparam int unsigned MAX   = 1522;
  localparam int unsigned LEN_W = $clog2(MAX + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             encoded = 1'b1;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_sof;
  logic             done;
  logic             done_err;
  logic [LEN_W-1:0] done_len;
  logic [15:0]      src_port;
  logic [15:0]      dst_port;
  logic             ports_valid;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]       rx_q[$];
  int               sof_cnt;
  int               sof_first;
  int               done_cnt;
  logic             last_err;
  logic [LEN_W-1:0] last_len;
  logic [15:0]      last_src, last_dst;
  logic             last_pv;

  manchester_frame_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .encoded     (encoded),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_sof       (m_sof),
    .done        (done),
    .done_err    (done_err),
    .done_len    (done_len),
    .src_port    (src_port),
    .dst_port    (dst_port),
    .ports_valid (ports_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_sof) begin
        sof_cnt++;
        if (rx_q.size() == 0) sof_first = 1;
      end
      rx_q.push_back(m_data);
    end
    if (done) begin
      done_cnt++;
      last_err = done_err;
      last_len = done_len;
      last_src = src_port;
      last_dst = dst_port;
      last_pv  = ports_valid;
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    sof_cnt   = 0;
    sof_first = 0;
    done_cnt  = 0;
    last_err  = 1'bx;
    last_len  = 'x;
    last_pv   = 1'bx;
  endtask

  task automatic send_sample(input logic s);
    @(negedge clk);
    encoded = s;
  endtask

  task automatic send_bit(input logic b);
    send_sample(~b);
    send_sample(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_sample(1'b1);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic check_seq(input string name, input int n);
    int bad;
    bad = 0;
    n_total++;
    if (rx_q.size() != n) begin
      $display("FAIL %s byte count: got %0d expected %0d", name, rx_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) if (rx_q[i] !== 8'(i)) bad++;
      if (bad != 0) $display("FAIL %s byte values: %0d wrong bytes, expected 0..%0d", name, bad, n - 1);
      else n_pass++;
    end
  endtask

  task automatic check_done(input string name, input logic err, input int len);
    n_total++;
    if (done_cnt !== 1) $display("FAIL %s done count: got %0d expected 1", name, done_cnt);
    else n_pass++;
    n_total++;
    if (last_err !== err) $display("FAIL %s done_err: got %b expected %b", name, last_err, err);
    else n_pass++;
    n_total++;
    if (last_len !== LEN_W'(len)) $display("FAIL %s done_len: got %0d expected %0d", name, last_len, len);
    else n_pass++;
  endtask

  task automatic check_ports(input string name);
    n_total++;
    if (last_pv !== 1'b1) $display("FAIL %s ports_valid: got %b expected 1", name, last_pv);
    else n_pass++;
    n_total++;
    if (last_src !== 16'h2223) $display("FAIL %s src_port: got %h expected 2223", name, last_src);
    else n_pass++;
    n_total++;
    if (last_dst !== 16'h2425) $display("FAIL %s dst_port: got %h expected 2425", name, last_dst);
    else n_pass++;
  endtask

  task automatic check_sof(input string name);
    n_total++;
    if (sof_cnt !== 1 || sof_first !== 1)
      $display("FAIL %s m_sof: got count %0d first %0d expected 1 1", name, sof_cnt, sof_first);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    encoded = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({m_valid, m_sof, done, done_err, ports_valid} !== 5'b0 || m_data !== 8'h00 ||
        done_len !== '0 || src_port !== 16'h0 || dst_port !== 16'h0)
      $display("FAIL reset outputs: got v%b s%b d%b e%b pv%b data %h len %0d src %h dst %h expected all 0",
               m_valid, m_sof, done, done_err, ports_valid, m_data, done_len, src_port, dst_port);
    else n_pass++;
    rst_n = 1'b1;
    clear_mon();
    send_idle(40);
    n_total++;
    if (rx_q.size() != 0 || done_cnt != 0)
      $display("FAIL idle quiet: got %0d bytes %0d done expected 0 0", rx_q.size(), done_cnt);
    else n_pass++;
  endtask

  task automatic test_frame();
    clear_mon();
    send_preamble();
    for (int i = 0; i < 60; i++) send_byte(8'(i));
    send_idle(4);
    settle();
    check_seq("frame", 60);
    check_sof("frame");
    check_done("frame", 1'b0, 60);
    check_ports("frame");
  endtask

  task automatic test_phase_shift();
    clear_mon();
    send_sample(1'b0);
    send_preamble();
    for (int i = 0; i < 60; i++) send_byte(8'(i));
    send_idle(4);
    settle();
    check_seq("phase", 60);
    check_sof("phase");
    check_done("phase", 1'b0, 60);
    check_ports("phase");
  endtask

  task automatic test_violation();
    logic [7:0] b20;
    b20 = 8'd20;
    clear_mon();
    send_preamble();
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    for (int i = 0; i < 3; i++) send_bit(b20[i]);
    send_sample(1'b0);
    send_sample(1'b0);
    send_idle(8);
    settle();
    check_seq("violation", 20);
    check_done("violation", 1'b1, 20);
    n_total++;
    if (last_pv !== 1'b0) $display("FAIL violation ports_valid: got %b expected 0", last_pv);
    else n_pass++;
  endtask

  task automatic test_overflow();
    clear_mon();
    send_preamble();
    for (int i = 0; i < MAX + 5; i++) send_byte(8'(i));
    send_idle(4);
    settle();
    check_seq("overflow", MAX);
    check_done("overflow", 1'b1, MAX);
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_preamble();
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_idle(40);
    n_total++;
    if (done_cnt != 0) $display("FAIL midreset done: got %0d expected 0", done_cnt);
    else n_pass++;
    clear_mon();
    send_preamble();
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    send_idle(4);
    settle();
    check_seq("midreset", 64);
    check_done("midreset", 1'b0, 64);
    check_ports("midreset");
  endtask

`ifdef FCS_CHECK_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic send_fcs_frame(input logic flip);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    send_preamble();
    for (int i = 0; i < 60; i++) begin
      b = 8'(i);
      c = crc_upd(c, b);
      if (flip && i == 45) b = b ^ 8'h08;
      send_byte(b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) send_byte(c[8*i +: 8]);
    send_idle(4);
    settle();
  endtask

  task automatic test_fcs();
    clear_mon();
    send_fcs_frame(1'b0);
    check_done("fcs_good", 1'b0, 64);
    clear_mon();
    send_fcs_frame(1'b1);
    check_done("fcs_bad", 1'b1, 64);
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_phase_shift();
    test_violation();
    test_overflow();
    test_reset_mid_frame();
`ifdef FCS_CHECK_EN
    test_fcs();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
